// File: rtl/cdb_arbiter_pkg.sv
// Shared types and default widths for the CDB arbitration slice.
package cdb_arbiter_pkg;

    localparam int unsigned NUM_FU    = 4;
    localparam int unsigned ROB_IDX_W = 5;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned DATA_W    = 32;

    // One CDB broadcast beat.
    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_id;
        logic [REG_IDX_W-1:0] rd_addr;
        logic [DATA_W-1:0]    data;
    } cdb_t;

    // Writes to x0 must never carry a value onto the bus.
    function automatic logic [DATA_W-1:0] x0_filter(input logic [REG_IDX_W-1:0] rd_addr,
                                                    input logic [DATA_W-1:0]    data);
        return (rd_addr == '0) ? '0 : data;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-to-arbiter handshake plus the registered CDB broadcast.
interface cdb_arbiter_if #(
    parameter int unsigned NUM_FU    = cdb_arbiter_pkg::NUM_FU,
    parameter int unsigned ROB_IDX_W = cdb_arbiter_pkg::ROB_IDX_W,
    parameter int unsigned REG_IDX_W = cdb_arbiter_pkg::REG_IDX_W,
    parameter int unsigned DATA_W    = cdb_arbiter_pkg::DATA_W
);

    logic [NUM_FU-1:0]                fu_valid;
    logic [NUM_FU-1:0]                fu_ready;
    logic [NUM_FU-1:0][ROB_IDX_W-1:0] fu_rob_id;
    logic [NUM_FU-1:0][REG_IDX_W-1:0] fu_rd_addr;
    logic [NUM_FU-1:0][DATA_W-1:0]    fu_data;

    logic                             cdb_valid;
    logic [ROB_IDX_W-1:0]             cdb_rob_id;
    logic [REG_IDX_W-1:0]             cdb_rd_addr;
    logic [DATA_W-1:0]                cdb_data;

    // FU and CDB-consumer side.
    modport master (
        output fu_valid, fu_rob_id, fu_rd_addr, fu_data,
        input  fu_ready, cdb_valid, cdb_rob_id, cdb_rd_addr, cdb_data
    );

    // Arbiter side.
    modport slave (
        input  fu_valid, fu_rob_id, fu_rd_addr, fu_data,
        output fu_ready, cdb_valid, cdb_rob_id, cdb_rd_addr, cdb_data
    );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [IdxW-1:0] grant_idx
);

    // Scan N slots starting at ptr; only the first hit is granted.
    always_comb begin
        logic            found;
        logic [IdxW-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IdxW'((32'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one FU result per cycle, broadcast one cycle after grant.
module cdb_arbiter #(
    parameter int unsigned NUM_FU    = cdb_arbiter_pkg::NUM_FU,
    parameter int unsigned ROB_IDX_W = cdb_arbiter_pkg::ROB_IDX_W,
    parameter int unsigned REG_IDX_W = cdb_arbiter_pkg::REG_IDX_W,
    parameter int unsigned DATA_W    = cdb_arbiter_pkg::DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);

    localparam int unsigned IdxW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]    req;
    logic [NUM_FU-1:0]    grant;
    logic [IdxW-1:0]      grant_idx;
    logic                 grant_any;

    logic [IdxW-1:0]      ptr_q, ptr_d;
    logic                 cdb_valid_q, cdb_valid_d;
    logic [ROB_IDX_W-1:0] cdb_rob_id_q, cdb_rob_id_d;
    logic [REG_IDX_W-1:0] cdb_rd_addr_q, cdb_rd_addr_d;
    logic [DATA_W-1:0]    cdb_data_q, cdb_data_d;

    // Reset and flush suppress all grants in the same cycle.
    assign req = bus.fu_valid & {NUM_FU{~(rst | flush)}};

    rr_arbiter #(
        .N    (NUM_FU),
        .IdxW (IdxW)
    ) u_rr_arbiter (
        .req       (req),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign grant_any    = |grant;
    assign bus.fu_ready = grant;

    // Next pointer and next broadcast beat from this cycle's grant.
    always_comb begin
        ptr_d         = ptr_q;
        cdb_valid_d   = grant_any;
        cdb_rob_id_d  = cdb_rob_id_q;
        cdb_rd_addr_d = cdb_rd_addr_q;
        cdb_data_d    = cdb_data_q;
        if (grant_any) begin
            ptr_d         = (grant_idx == IdxW'(NUM_FU - 1)) ? '0 : grant_idx + IdxW'(1);
            cdb_rob_id_d  = bus.fu_rob_id[grant_idx];
            cdb_rd_addr_d = bus.fu_rd_addr[grant_idx];
            // x0 destination: tag still goes out so the ROB can retire it.
            cdb_data_d    = (bus.fu_rd_addr[grant_idx] == '0) ? '0 : bus.fu_data[grant_idx];
        end
    end

    // Pointer and registered CDB stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= '0;
            cdb_valid_q   <= 1'b0;
            cdb_rob_id_q  <= '0;
            cdb_rd_addr_q <= '0;
            cdb_data_q    <= '0;
        end else begin
            ptr_q         <= ptr_d;
            cdb_valid_q   <= cdb_valid_d;
            cdb_rob_id_q  <= cdb_rob_id_d;
            cdb_rd_addr_q <= cdb_rd_addr_d;
            cdb_data_q    <= cdb_data_d;
        end
    end

    assign bus.cdb_valid   = cdb_valid_q;
    assign bus.cdb_rob_id  = cdb_rob_id_q;
    assign bus.cdb_rd_addr = cdb_rd_addr_q;
    assign bus.cdb_data    = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed expected grants and broadcasts.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int unsigned NFU = 4;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_FU(NFU)) bus ();

    cdb_arbiter #(.NUM_FU(NFU)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(input int i, input logic [4:0] rob, input logic [4:0] rd,
                          input logic [31:0] d);
        bus.fu_rob_id[i]  = rob;
        bus.fu_rd_addr[i] = rd;
        bus.fu_data[i]    = d;
    endtask

    // Drive one cycle, check the combinational grant, then move past the edge.
    task automatic cyc(input string tag, input logic [3:0] v, input logic f, input logic r,
                       input logic [3:0] exp_ready);
        bus.fu_valid = v;
        flush        = f;
        rst          = r;
        #1;
        check({tag, "_ready"}, 32'(bus.fu_ready), 32'(exp_ready));
        next_cycle();
    endtask

    task automatic check_cdb(input string tag, input cdb_t exp);
        check({tag, "_valid"}, 32'(bus.cdb_valid), 32'(exp.valid));
        if (exp.valid) begin
            check({tag, "_rob"},  32'(bus.cdb_rob_id),  32'(exp.rob_id));
            check({tag, "_rd"},   32'(bus.cdb_rd_addr), 32'(exp.rd_addr));
            check({tag, "_data"}, bus.cdb_data,         exp.data);
        end
    endtask

    task automatic check_ptr(input string tag, input int unsigned exp);
        check({tag, "_ptr"}, 32'(dut.ptr_q), exp);
    endtask

    function automatic cdb_t fu_beat(input int unsigned i);
        cdb_t b;
        b.valid   = 1'b1;
        b.rob_id  = 5'(10 + i);
        b.rd_addr = 5'(i + 1);
        b.data    = 32'hA000_0000 + i;
        return b;
    endfunction

    cdb_t idle_beat;
    cdb_t exp_beat;

    initial begin
        idle_beat = '0;
        for (int i = 0; i < NFU; i++) set_fu(i, 5'(10 + i), 5'(i + 1), 32'hA000_0000 + i);

        // Reset held with all FUs requesting: no grants, outputs cleared.
        rst          = 1'b1;
        flush        = 1'b0;
        bus.fu_valid = 4'hF;
        #1;
        check("rst_ready", 32'(bus.fu_ready), 32'h0);
        next_cycle();
        next_cycle();
        check("rst_ready2", 32'(bus.fu_ready), 32'h0);
        check("rst_valid", 32'(bus.cdb_valid), 32'h0);
        check("rst_rob", 32'(bus.cdb_rob_id), 32'h0);
        check("rst_rd", 32'(bus.cdb_rd_addr), 32'h0);
        check("rst_data", bus.cdb_data, 32'h0);
        check_ptr("rst", 0);

        // Idle: nothing offered.
        for (int k = 0; k < 3; k++) begin
            cyc("idle", 4'b0000, 1'b0, 1'b0, 4'b0000);
            check_cdb("idle", idle_beat);
            check_ptr("idle", 0);
        end

        // Single request from FU2.
        set_fu(2, 5'd7, 5'd3, 32'hDEAD_BEEF);
        cyc("single", 4'b0100, 1'b0, 1'b0, 4'b0100);
        exp_beat = '{valid: 1'b1, rob_id: 5'd7, rd_addr: 5'd3, data: 32'hDEAD_BEEF};
        check_cdb("single", exp_beat);
        check_ptr("single", 3);

        // Mid-operation reset returns the pointer to 0.
        set_fu(2, 5'd12, 5'd3, 32'hA000_0002);
        cyc("rst_mid", 4'hF, 1'b0, 1'b1, 4'b0000);
        check_cdb("rst_mid", idle_beat);
        check_ptr("rst_mid", 0);

        // All four continuously valid: 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            cyc("rr", 4'hF, 1'b0, 1'b0, 4'(1 << (k % 4)));
            check_cdb("rr", fu_beat(k % 4));
            check_ptr("rr", (k % 4 + 1) % 4);
        end

        // Wrap: move ptr to 3, then FU3 and FU0 compete.
        cyc("pre_wrap", 4'b0100, 1'b0, 1'b0, 4'b0100);
        check_cdb("pre_wrap", fu_beat(2));
        check_ptr("pre_wrap", 3);
        cyc("wrap3", 4'b1001, 1'b0, 1'b0, 4'b1000);
        check_cdb("wrap3", fu_beat(3));
        check_ptr("wrap3", 0);
        cyc("wrap0", 4'b0001, 1'b0, 1'b0, 4'b0001);
        check_cdb("wrap0", fu_beat(0));
        check_ptr("wrap0", 1);

        // x0 destination: tag broadcast, data forced to zero.
        set_fu(1, 5'd9, 5'd0, 32'h0000_1234);
        cyc("x0", 4'b0010, 1'b0, 1'b0, 4'b0010);
        exp_beat = '{valid: 1'b1, rob_id: 5'd9, rd_addr: 5'd0, data: 32'h0};
        check_cdb("x0", exp_beat);
        check_ptr("x0", 2);

        // Grant FU2 in T, flush in T+1.
        cyc("fl_a_grant", 4'b0100, 1'b0, 1'b0, 4'b0100);
        check_cdb("fl_a_t1", fu_beat(2));
        check_ptr("fl_a_t1", 3);
        cyc("fl_a_flush", 4'hF, 1'b1, 1'b0, 4'b0000);
        check_cdb("fl_a_t2", idle_beat);
        check_ptr("fl_a_t2", 3);

        // Request and flush in the same cycle.
        cyc("fl_b", 4'b0001, 1'b1, 1'b0, 4'b0000);
        check_cdb("fl_b", idle_beat);
        check_ptr("fl_b", 3);

        // Flush and reset together: reset wins.
        cyc("fl_rst", 4'hF, 1'b1, 1'b1, 4'b0000);
        check_cdb("fl_rst", idle_beat);
        check_ptr("fl_rst", 0);

        // Back to normal after reset.
        cyc("post", 4'b1000, 1'b0, 1'b0, 4'b1000);
        check_cdb("post", fu_beat(3));
        check_ptr("post", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter that shares the single common data bus (CDB) among the out-of-order core's functional units (ALU, multiplier, divider, load unit).
- Each FU offers one completed result per cycle through a valid/ready handshake. The arbiter grants one FU per cycle and broadcasts the winner's result on a registered CDB.
- CDB consumers: ROB, reservation stations, register-file/RAT writeback.
- Sits between the FU outputs and the CDB broadcast stage.

Parameters:
- NUM_FU, 4, number of requesting functional units (2..8).
- ROB_IDX_W, 5, width of ROB index tag.
- REG_IDX_W, 5, width of architectural destination register index.
- DATA_W, 32, result data width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  pipeline flush (branch mispredict); discards in-flight broadcast.
- fu_valid  in  NUM_FU  FU i has a result offered.
- fu_ready  out  NUM_FU  FU i's result is accepted this cycle (one-hot or zero).
- fu_rob_id  in  NUM_FU x ROB_IDX_W  ROB tag per FU.
- fu_rd_addr  in  NUM_FU x REG_IDX_W  destination register per FU.
- fu_data  in  NUM_FU x DATA_W  result value per FU.
- cdb_valid  out  1  broadcast valid.
- cdb_rob_id  out  ROB_IDX_W  broadcast ROB tag.
- cdb_rd_addr  out  REG_IDX_W  broadcast destination register.
- cdb_data  out  DATA_W  broadcast value.

Behaviour:
- Reset: cdb_valid=0, cdb_rob_id/rd_addr/data=0, priority pointer=0. fu_ready=0 while rst=1.
- Handshake: transfer from FU i occurs when fu_valid[i] & fu_ready[i]. fu_ready is combinational from fu_valid, pointer and flush.
- An FU holds valid and payload stable until accepted. The arbiter never asserts fu_ready[i] when fu_valid[i]=0.
- Arbitration: search starts at index ptr and wraps modulo NUM_FU. The first FU with fu_valid=1 gets fu_ready=1; at most one grant per cycle.
- Pointer update: on a grant to FU w, ptr <= (w+1) mod NUM_FU. With no grant, ptr holds. Wrap: w=NUM_FU-1 gives ptr=0.
- Latency: granted in cycle T, broadcast on cdb_* in cycle T+1 for exactly one cycle. There is no CDB back-pressure; the CDB always consumes.
- No grant in cycle T: cdb_valid=0 in T+1. Payload outputs hold their previous value and are don't-care when invalid.
- x0 rule: if the granted fu_rd_addr==0, cdb_data is forced to 0. The tag is still broadcast so the ROB can retire the entry.
- Flush in cycle T:
  - fu_ready all 0 in T.
  - cdb_valid=0 in T+1, even if a grant occurred in T-1.
  - ptr unchanged.
- Flush and rst simultaneous: rst wins.
- Reset mid-operation: any pending broadcast is dropped and the pointer returns to 0.
- Fairness: a continuously valid FU is granted within NUM_FU cycles.

Decomposition:
- Shared package rv32i_types gains cdb_t, a packed struct {valid, rob_id, rd_addr, data}, plus constants ROB_IDX_W and REG_IDX_W.
- Sub-module rr_arbiter (parameter N): inputs req[N], ptr; outputs grant one-hot and grant_idx. Purely combinational.
- cdb_arbiter owns the pointer register, the output register, and the flush/x0 logic.

Test Plan:
- Reset, then fu_valid=4'b0000 -> cdb_valid=0, fu_ready=0 every cycle; ptr stays 0.
- Single request: fu_valid=4'b0100, rob_id=7, rd=3, data=0xDEADBEEF -> fu_ready=4'b0100 same cycle; next cycle cdb_valid=1, rob_id=7, rd=3, data=0xDEADBEEF; ptr=3.
- All four valid continuously from ptr=0 -> grants 0,1,2,3,0 on consecutive cycles; each broadcast one cycle later.
- Wrap: ptr=3, fu_valid=4'b1001 -> grant FU3 then FU0; ptr sequence 0 then 1.
- x0: grant FU1 with rd=0, data=0x1234 -> cdb_valid=1, rob_id passed, cdb_data=0.
- Flush:
  - Grant FU2 in T, flush in T+1: cdb_valid=1 in T+1; fu_ready=0 in T+1; cdb_valid=0 in T+2; ptr=3 preserved.
  - Grant in T with flush in T: fu_ready=0 in T, no broadcast in T+1.
